// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Optional feature macro used by the divider: DIVZERO_DETECT_EN.
package divider_pkg;

  localparam int DIV_WIDTH_DEF = 4;
  localparam int CNT_W         = $clog2(DIV_WIDTH_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step-counter width needed to count up to 'width' steps.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_subtract_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// conditionally subtract the divisor, emit the quotient bit.
module div_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_r,
  output logic             o_q
);

  logic [WIDTH:0] w_t;
  logic [WIDTH:0] w_dvs;
  logic [WIDTH:0] w_diff;

  // Trial subtraction; keep the difference only when it does not underflow.
  always_comb begin
    w_t    = {i_r, i_bit};
    w_dvs  = {1'b0, i_divisor};
    w_diff = w_t - w_dvs;
    o_q    = (w_t >= w_dvs);
    o_r    = o_q ? w_diff[WIDTH-1:0] : w_t[WIDTH-1:0];
  end

endmodule

// File: rtl/shift_subtract_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock,
// with a start/busy/done handshake.
// Optional feature: define DIVZERO_DETECT_EN to short-circuit a zero
// divisor straight to DONE and flag it on div_by_zero.
module shift_subtract_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int                 LCNT_W = cnt_width(WIDTH);
  localparam logic [LCNT_W-1:0]  LAST   = LCNT_W'(WIDTH - 1);

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;

  // r_work starts as the dividend; each step shifts one dividend bit out of
  // the top and one quotient bit in at the bottom, so after WIDTH steps it
  // holds the quotient.
  logic [WIDTH-1:0]    r_work;
  logic [WIDTH-1:0]    r_dvs;
  logic [WIDTH-1:0]    r_rem;
  logic [LCNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]    r_quotient;
  logic [WIDTH-1:0]    r_remainder;
`ifdef DIVZERO_DETECT_EN
  logic                r_dbz;
`endif

  logic [WIDTH-1:0]    w_step_r;
  logic                w_qbit;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_r       (r_rem),
    .i_bit     (r_work[WIDTH-1]),
    .i_divisor (r_dvs),
    .o_r       (w_step_r),
    .o_q       (w_qbit)
  );

  // A start is only honoured when no division is running.
  always_comb begin
    w_accept = start && (r_state != RUN);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
`ifdef DIVZERO_DETECT_EN
          w_next = (divisor == '0) ? DONE : RUN;
`else
          w_next = RUN;
`endif
        end else begin
          w_next = IDLE;
        end
      end
      RUN:     if (r_cnt == LAST) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iterative step, result load on the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work      <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
`ifdef DIVZERO_DETECT_EN
      r_dbz       <= 1'b0;
`endif
    end else if (w_accept) begin
      r_work <= dividend;
      r_dvs  <= divisor;
      r_rem  <= '0;
      r_cnt  <= '0;
`ifdef DIVZERO_DETECT_EN
      r_dbz  <= 1'b0;
      if (divisor == '0) begin
        r_quotient  <= '1;
        r_remainder <= dividend;
        r_dbz       <= 1'b1;
      end
`endif
    end else if (r_state == RUN) begin
      r_rem  <= w_step_r;
      r_work <= {r_work[WIDTH-2:0], w_qbit};
      r_cnt  <= r_cnt + LCNT_W'(1);
      if (r_cnt == LAST) begin
        r_quotient  <= {r_work[WIDTH-2:0], w_qbit};
        r_remainder <= w_step_r;
      end
    end
  end

  // Output decode.
  always_comb begin
    busy      = (r_state == RUN);
    done      = (r_state == DONE);
    quotient  = r_quotient;
    remainder = r_remainder;
`ifdef DIVZERO_DETECT_EN
    div_by_zero = r_dbz;
`else
    div_by_zero = 1'b0;
`endif
  end

endmodule

// File: tb/tb_shift_subtract_divider.sv
// Scoreboard bench for shift_subtract_divider: the driver pushes expected
// results computed with plain / and %, a monitor checks handshake timing
// every cycle and pops/compares results whenever done is seen.
module tb_shift_subtract_divider;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor  = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  shift_subtract_divider #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int q;
    int r;
    int dbz;
    int sc;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   act_start = -1;
  int   act_lat = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int lat_of(input int b);
`ifdef DIVZERO_DETECT_EN
    if (b == 0) return 1;
`endif
    return W + 1;
  endfunction

  function automatic int dbz_of(input int b);
`ifdef DIVZERO_DETECT_EN
    return (b == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // Monitor: handshake timing every cycle, results on every done.
  always @(negedge clk) begin
    logic eb, ed;
    exp_t e;
    if (mon_en) begin
      eb = (act_start >= 0) && (cyc >= act_start + 1) && (cyc <= act_start + act_lat - 1);
      ed = (act_start >= 0) && (cyc == act_start + act_lat);
      check("busy", busy, eb);
      check("done", done, ed);
      if (done === 1'b1) begin
        check("result_pending", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("quotient", quotient, e.q);
          check("remainder", remainder, e.r);
          check("div_by_zero", div_by_zero, e.dbz);
          check("latency", cyc - e.sc, e.lat);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input int a, input int b);
    exp_t e;
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    e.q   = (b == 0) ? MAXV : a / b;
    e.r   = (b == 0) ? a : a % b;
    e.dbz = dbz_of(b);
    e.sc  = cyc;
    e.lat = lat_of(b);
    sb.push_back(e);
    act_start = cyc;
    act_lat   = e.lat;
    tick();
    start = 1'b0;
  endtask

  // Start pulse while busy with unrelated operands; must have no effect.
  task automatic noise();
    start    = 1'b1;
    dividend = W'(15);
    divisor  = W'(1);
    tick();
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("done_within_budget", done, 1);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_quotient"}, quotient, 0);
    check({tag, "_remainder"}, remainder, 0);
    check({tag, "_div_by_zero"}, div_by_zero, 0);
  endtask

  initial begin
    int a, b, gap;
    repeat (2) tick();
    check_idle_zero("reset");
    rst    = 1'b0;
    mon_en = 1'b1;
    tick();

    // 13/4 with an ignored start during busy, then back-to-back 15/1.
    issue(13, 4);
    tick();
    noise();
    wait_done();
    issue(15, 1);
    wait_done();

    // Reset in cycle 2 of a division: aborted, no done, outputs cleared.
    issue(13, 4);
    tick();
    rst = 1'b1;
    void'(sb.pop_back());
    act_start = -1;
    tick();
    check_idle_zero("midrst");
    rst = 1'b0;
    tick();

    issue(7, 9);
    wait_done();
    tick();
    issue(9, 0);
    wait_done();
    tick();

    // Full sweep, back-to-back.
    for (int i = 0; i <= MAXV; i++) begin
      for (int j = 0; j <= MAXV; j++) begin
        issue(i, j);
        wait_done();
      end
    end

    // Random operands, gaps and ignored starts.
    repeat (150) begin
      a = $urandom_range(0, MAXV);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MAXV);
      issue(a, b);
      if (b != 0 && $urandom_range(0, 1) == 1) begin
        tick();
        noise();
      end
      wait_done();
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
    end

    repeat (3) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
